// File: rtl/uart_boot_loader.sv
// uart_boot_loader: packs the received UART byte stream into little-endian
// 32-bit words and writes them to memory at consecutive word addresses over a
// valid/ready port. Loading ends on a word-count limit or a line-idle timeout;
// the sticky `done` then releases the CPU from its boot hold.
// Optional feature: define UART_BOOT_LOADER_CHECKSUM_EN to build the running
// sum of accepted words on `checksum`; otherwise `checksum` is constant 0.
module uart_boot_loader #(
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter logic [31:0] MAX_WORDS   = 32'h7fff,
  parameter logic [31:0] IDLE_CYCLES = 32'd13888
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic        mem_ready,
  output logic        done,
  output logic        overflow,
  output logic [31:0] word_cnt,
  output logic [31:0] checksum
);

  typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_WRITE, S_FLUSH, S_DONE} state_t;

  state_t      r_state;
  logic [31:0] r_addr, r_wdata, r_cnt, r_idle;
  logic        r_we, r_done, r_ovf, r_skid_vld;
  logic [7:0]  r_skid;
  logic [1:0]  r_lane;

  logic [31:0] w_idle_nxt;
  logic        w_idle_hit, w_accept, w_last, w_src_vld, w_take;
  logic [7:0]  w_src;

  // next idle-timer value: cleared by a byte, otherwise counts up and saturates
  always_comb begin
    w_idle_nxt = r_idle;
    if (byte_valid)                w_idle_nxt = '0;
    else if (r_idle < IDLE_CYCLES) w_idle_nxt = r_idle + 32'd1;
  end

  // the timeout fires on the edge the timer saturates and stays asserted after
  assign w_idle_hit = (r_state != S_IDLE) && (w_idle_nxt == IDLE_CYCLES);
  assign w_accept   = r_we && mem_ready;
  assign w_last     = (r_cnt + 32'd1) == MAX_WORDS;
  // a held skid byte is older than any live strobe, so it is packed first
  assign w_src_vld  = r_skid_vld || byte_valid;
  assign w_src      = r_skid_vld ? r_skid : byte_in;
  // skid byte moves into lane 0 on an acceptance that returns to COLLECT,
  // which frees the skid for a byte arriving in that same cycle
  assign w_take     = w_accept && (r_state == S_WRITE) && !w_last && r_skid_vld;

  // loader FSM: byte packing, write handshake, skid capture, timeout, done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_addr     <= BASE_ADDR;
      r_wdata    <= '0;
      r_cnt      <= '0;
      r_idle     <= '0;
      r_we       <= 1'b0;
      r_done     <= 1'b0;
      r_ovf      <= 1'b0;
      r_skid     <= '0;
      r_skid_vld <= 1'b0;
      r_lane     <= '0;
    end else begin
      if (r_state != S_IDLE && r_state != S_DONE) r_idle <= w_idle_nxt;
      case (r_state)
        S_IDLE: begin
          if (byte_valid) begin
            r_wdata <= {24'h0, byte_in};
            r_lane  <= 2'd1;
            r_state <= S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (w_src_vld) begin
            case (r_lane)
              2'd0: r_wdata        <= {24'h0, w_src};
              2'd1: r_wdata[15:8]  <= w_src;
              2'd2: r_wdata[23:16] <= w_src;
              default: r_wdata[31:24] <= w_src;
            endcase
            r_lane <= r_lane + 2'd1;
            // skid stays full only if it fed this lane and a new byte refilled it
            r_skid_vld <= r_skid_vld && byte_valid;
            if (r_skid_vld && byte_valid) r_skid <= byte_in;
            if (r_lane == 2'd3) begin
              r_we    <= 1'b1;
              r_state <= S_WRITE;
            end
          end else if (w_idle_hit) begin
            if (r_lane == 2'd0) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_we    <= 1'b1;
              r_state <= S_FLUSH;
            end
          end
        end
        S_WRITE, S_FLUSH: begin
          if (byte_valid) begin
            if (!r_skid_vld || w_take) begin
              r_skid     <= byte_in;
              r_skid_vld <= 1'b1;
            end else begin
              r_ovf <= 1'b1;
            end
          end else if (w_take) begin
            r_skid_vld <= 1'b0;
          end
          if (w_accept) begin
            r_we   <= 1'b0;
            r_addr <= r_addr + 32'd1;
            r_cnt  <= r_cnt + 32'd1;
            if (r_state == S_FLUSH || w_last) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else if (r_skid_vld) begin
              r_wdata <= {24'h0, r_skid};
              r_lane  <= 2'd1;
              r_state <= S_COLLECT;
            end else if (w_idle_hit) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_state <= S_COLLECT;
            end
          end
        end
        S_DONE: begin
          r_we <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef UART_BOOT_LOADER_CHECKSUM_EN
  logic [31:0] r_cks;

  // running sum of every word the memory accepts, flush word included
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_cks <= '0;
    else if (w_accept) r_cks <= r_cks + r_wdata;
  end

  assign checksum = r_cks;
`else
  assign checksum = 32'h0;
`endif

  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_we    = r_we;
  assign done      = r_done;
  assign overflow  = r_ovf;
  assign word_cnt  = r_cnt;

endmodule

// File: tb/tb_uart_boot_loader.sv
// tb_uart_boot_loader: drives two loaders (large and tiny word limit) from one
// byte stream; a byte-list model predicts every write, the final counters,
// checksum, overflow and done.
module tb_uart_boot_loader;
  localparam logic [31:0] IDLE  = 32'd40;
  localparam logic [31:0] BASE0 = 32'hFFFF_FFFE;
  localparam logic [31:0] MAX0  = 32'd64;
  localparam logic [31:0] BASE1 = 32'h0000_0100;
  localparam logic [31:0] MAX1  = 32'd2;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  byte_in = 8'h0;
  logic        byte_valid = 1'b0;
  logic        mem_ready;
  logic [31:0] addr [2];
  logic [31:0] wdata[2];
  logic [31:0] cnt  [2];
  logic [31:0] cks  [2];
  logic        we   [2];
  logic        dn   [2];
  logic        ovf  [2];

  int n_chk = 0;
  int n_err = 0;
  int acc[2];
  int rdy_mode = 0;
  logic rdy_man = 1'b1;
  logic [7:0] kb[$];
  bit dropped;

  always #5 clk = ~clk;

  uart_boot_loader #(.BASE_ADDR(BASE0), .MAX_WORDS(MAX0), .IDLE_CYCLES(IDLE)) u_dut (
    .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid),
    .mem_addr(addr[0]), .mem_wdata(wdata[0]), .mem_we(we[0]), .mem_ready(mem_ready),
    .done(dn[0]), .overflow(ovf[0]), .word_cnt(cnt[0]), .checksum(cks[0]));

  uart_boot_loader #(.BASE_ADDR(BASE1), .MAX_WORDS(MAX1), .IDLE_CYCLES(IDLE)) u_max (
    .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid),
    .mem_addr(addr[1]), .mem_wdata(wdata[1]), .mem_we(we[1]), .mem_ready(mem_ready),
    .done(dn[1]), .overflow(ovf[1]), .word_cnt(cnt[1]), .checksum(cks[1]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] base_of(input int k);
    return (k == 0) ? BASE0 : BASE1;
  endfunction

  function automatic int max_of(input int k);
    return (k == 0) ? int'(MAX0) : int'(MAX1);
  endfunction

  // word i of the kept byte stream, little-endian, missing upper bytes zero
  function automatic logic [31:0] exp_word(input int i);
    logic [31:0] w = '0;
    for (int j = 0; j < 4; j++)
      if (4 * i + j < kb.size()) w[8*j +: 8] = kb[4*i+j];
    return w;
  endfunction

  function automatic int exp_nw(input int k);
    int n = (kb.size() + 3) / 4;
    return (n > max_of(k)) ? max_of(k) : n;
  endfunction

  function automatic logic [31:0] exp_cks(input int k);
    logic [31:0] s = '0;
    for (int i = 0; i < exp_nw(k); i++) s += exp_word(i);
`ifndef UART_BOOT_LOADER_CHECKSUM_EN
    s = '0;
`endif
    return s;
  endfunction

  // memory ready: 0 always ready, 1 random with at most one stall cycle, 2 manual
  initial begin
    mem_ready = 1'b1;
    forever begin
      @(posedge clk); #2;
      case (rdy_mode)
        0: mem_ready = 1'b1;
        1: mem_ready = mem_ready ? 1'(($urandom & 1)) : 1'b1;
        default: mem_ready = rdy_man;
      endcase
    end
  end

  // write-port monitor: every pending write must show the next expected word
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int k = 0; k < 2; k++) begin
          if (we[k]) begin
            chk($sformatf("wr_addr%0d", k), addr[k], base_of(k) + 32'(acc[k]));
            chk($sformatf("wr_data%0d", k), wdata[k], exp_word(acc[k]));
            if (mem_ready) acc[k]++;
          end
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1'b1;
    byte_valid = 1'b0;
    rdy_mode = 0;
    rdy_man = 1'b1;
    kb.delete();
    dropped = 1'b0;
    acc[0] = 0;
    acc[1] = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input bit keep, input int gap);
    @(posedge clk); #2;
    byte_in = b;
    byte_valid = 1'b1;
    if (keep) kb.push_back(b);
    else dropped = 1'b1;
    @(posedge clk); #2;
    byte_valid = 1'b0;
    byte_in = 8'($urandom);
    repeat (gap) @(posedge clk);
  endtask

  task automatic chk_rst_vals(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk({tag, "_addr"}, addr[k], base_of(k));
      chk({tag, "_wdata"}, wdata[k], 32'h0);
      chk({tag, "_we"}, 32'(we[k]), 32'h0);
      chk({tag, "_done"}, 32'(dn[k]), 32'h0);
      chk({tag, "_ovf"}, 32'(ovf[k]), 32'h0);
      chk({tag, "_cnt"}, cnt[k], 32'h0);
      chk({tag, "_cks"}, cks[k], 32'h0);
    end
  endtask

  // wait (bounded) for both loaders to finish, then check the final state
  task automatic finish_chk(input string tag);
    int t = 0;
    while (!(dn[0] && dn[1]) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_done_wait"}, {30'h0, dn[1], dn[0]}, 32'h3);
    repeat (4) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s_cnt%0d", tag, k), cnt[k], 32'(exp_nw(k)));
      chk($sformatf("%s_nwr%0d", tag, k), 32'(acc[k]), 32'(exp_nw(k)));
      chk($sformatf("%s_addr%0d", tag, k), addr[k], base_of(k) + 32'(exp_nw(k)));
      chk($sformatf("%s_we%0d", tag, k), 32'(we[k]), 32'h0);
      chk($sformatf("%s_ovf%0d", tag, k), 32'(ovf[k]), 32'(dropped));
      chk($sformatf("%s_cks%0d", tag, k), cks[k], exp_cks(k));
    end
  endtask

  initial begin
    rst = 1'b1;
    do_reset();
    chk_rst_vals("reset");

    // no byte yet: the timeout must not run
    repeat (3 * IDLE) @(negedge clk);
    chk("idle_nodone0", 32'(dn[0]), 32'h0);
    chk("idle_nodone1", 32'(dn[1]), 32'h0);

    // single word, always ready
    send(8'h78, 1, 2); send(8'h56, 1, 2); send(8'h34, 1, 2); send(8'h12, 1, 2);
    finish_chk("one_word");

    // first write stalled 5 cycles, then a second word
    do_reset();
    rdy_mode = 2; rdy_man = 1'b0;
    for (int i = 1; i <= 4; i++) send(8'(i), 1, 0);
    repeat (5) @(posedge clk);
    rdy_man = 1'b1;
    for (int i = 5; i <= 8; i++) send(8'(i), 1, 1);
    finish_chk("stall");

    // two bytes during a stalled write: first kept in skid, second dropped
    do_reset();
    rdy_mode = 2; rdy_man = 1'b0;
    for (int i = 1; i <= 4; i++) send(8'(i), 1, 0);
    send(8'h11, 1, 0);
    send(8'h22, 0, 0);
    repeat (2) @(posedge clk);
    rdy_man = 1'b1;
    send(8'h33, 1, 1); send(8'h44, 1, 1); send(8'h55, 1, 1);
    finish_chk("skid");

    // partial word flushed by timeout
    do_reset();
    send(8'hAA, 1, 2); send(8'hBB, 1, 2);
    finish_chk("flush");

    // word limit: tiny-limit instance stops after two words, no overflow
    do_reset();
    for (int i = 0; i < 12; i++) send(8'($urandom), 1, 2);
    finish_chk("maxw");

    // checksum wrap: FFFFFFFF + 00000002
    do_reset();
    for (int i = 0; i < 4; i++) send(8'hFF, 1, 1);
    send(8'h02, 1, 1); send(8'h00, 1, 1); send(8'h00, 1, 1); send(8'h00, 1, 1);
    finish_chk("cks");

    // randomized streams with random memory back-pressure
    for (int it = 0; it < 6; it++) begin
      int n;
      do_reset();
      rdy_mode = 1;
      n = $urandom_range(1, 40);
      for (int i = 0; i < n; i++) send(8'($urandom), 1, $urandom_range(0, 4));
      finish_chk($sformatf("rnd%0d", it));
    end

    // async reset in the middle of a stalled write
    do_reset();
    rdy_mode = 2; rdy_man = 1'b0;
    for (int i = 0; i < 4; i++) send(8'h5A + 8'(i), 1, 0);
    begin
      int t = 0;
      while (!we[0] && t < 20) begin
        @(negedge clk);
        t++;
      end
    end
    chk("midwr_we_up", 32'(we[0]), 32'h1);
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    chk_rst_vals("midwr");
    @(negedge clk);
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/uart_boot_loader.md
# uart_boot_loader

Downstream consumer of the UART receive path: takes the byte stream produced by the receiver and packs it into little-endian 32-bit words. Writes each word to instruction/data memory through a valid/ready write port at consecutive word addresses. Declares the download complete on word-limit or line-idle timeout, and the completion signal releases the CPU from its boot hold.

## Interface
- `BASE_ADDR`, default 32'h0: word address of the first word written.
- `MAX_WORDS`, default 32'h7fff: word count at which loading ends.
- `IDLE_CYCLES`, default 13888 (16 bit-times at 868 clk/bit): idle clocks after the last byte that end loading.
- `clk`, input, 1: system clock; all state updates on posedge.
- `rst`, input, 1: asynchronous, active-high reset.
- `byte_in`, input, 8: received byte; valid only when `byte_valid` is high.
- `byte_valid`, input, 1: single-cycle strobe, one per received byte.
- `mem_addr`, output, 32: word address of the pending write.
- `mem_wdata`, output, 32: packed word.
- `mem_we`, output, 1: write request; held until accepted.
- `mem_ready`, input, 1: memory accepts the write when `mem_we && mem_ready`.
- `done`, output, 1: sticky; loading finished.
- `overflow`, output, 1: sticky; a byte was dropped.
- `word_cnt`, output, 32: number of words accepted by memory.
- `checksum`, output, 32: running sum of accepted words (see Configuration).

## Operation
- FSM states: IDLE, COLLECT, WRITE, FLUSH, DONE.
- **IDLE**
  - No byte has been received yet. The idle timer does not run.
  - A `byte_valid` stores the byte in lane 0, sets `lane` to 1 and moves to COLLECT.
- **COLLECT**
  - Each `byte_valid` writes byte `lane` into bits [8*lane+7 : 8*lane]; `lane` is a 2-bit counter.
  - When the 4th byte (lane 3) is stored: go to WRITE, drive `mem_we`=1, `lane` wraps to 0.
  - The word is packed little-endian: the first byte lands in [7:0].
- **WRITE**
  - `mem_addr` and `mem_wdata` are held stable until the cycle in which `mem_ready`=1.
  - On acceptance: `mem_addr`+=1, `word_cnt`+=1, `mem_we` drops.
  - Next state is DONE if `word_cnt`+1 == `MAX_WORDS`, otherwise COLLECT.
- **Skid register (one byte)**
  - A `byte_valid` during WRITE or FLUSH is captured in the skid register.
  - On leaving WRITE for COLLECT, the skid byte becomes lane 0 and `lane`=1.
  - A further byte while the skid register is full is dropped and sets `overflow`.
  - A byte arriving in the exact acceptance cycle goes to the skid register, not directly to lane 0.
- **Idle timer**
  - Cleared on every `byte_valid`; otherwise increments and saturates at `IDLE_CYCLES`.
  - Reaching `IDLE_CYCLES` in COLLECT with `lane`=0 goes directly to DONE.
  - Reaching `IDLE_CYCLES` in COLLECT with `lane`≠0 goes to FLUSH.
  - Reaching `IDLE_CYCLES` in WRITE takes effect only after acceptance.
- **FLUSH**
  - Writes the partial word with unfilled upper lanes zero, using the WRITE handshake, then goes to DONE.
- **DONE**
  - Sticky until `rst`: `mem_we`=0, `done`=1.
  - All `byte_valid` are ignored; they do not set `overflow`.
- Address arithmetic is 32-bit and wraps modulo 2^32.
- `word_cnt` compare uses full 32 bits.

## Timing
- Reset values: `mem_addr`=`BASE_ADDR`, `mem_wdata`=0, `mem_we`=0, `done`=0, `overflow`=0, `word_cnt`=0, `checksum`=0, state IDLE, `lane`=0, skid empty, idle timer 0.
- `mem_we` rises on the clock edge that samples the 4th `byte_valid`, giving 1-cycle latency from strobe to request.
- With `mem_ready` tied high, a write completes 1 cycle after `mem_we` rises.
- `done` rises on the edge after the final acceptance, or on the edge the timer saturates when no write is pending.
- Async `rst` mid-write drops `mem_we` immediately. No partial state survives.
- All outputs are registered.

## Configuration
- Macro: `UART_BOOT_LOADER_CHECKSUM_EN`.
- Defined: `checksum` += `mem_wdata` (mod 2^32) on each accepted write, including the FLUSH write.
- Undefined: the accumulator is not built and `checksum` is constant 0.

## Test plan
- Reset, then bytes 0x78, 0x56, 0x34, 0x12 with `mem_ready`=1 -> one write: `mem_addr`=`BASE_ADDR`, `mem_wdata`=32'h12345678; then `word_cnt`=1.
- Eight bytes 0x01..0x08 with `mem_ready` held low for 5 cycles on the first write -> `mem_addr`/`mem_wdata`=32'h04030201 stable throughout the stall; second word 32'h08070605 at `BASE_ADDR`+1.
- Two bytes arrive during a stalled WRITE -> first byte becomes lane 0 of the next word; second byte dropped; `overflow`=1.
- Bytes 0xAA, 0xBB, then silence for `IDLE_CYCLES` -> FLUSH writes 32'h0000BBAA, then `done`=1 and `mem_we` stays 0.
- `MAX_WORDS`=2, 12 bytes sent -> exactly 2 writes, then `done`=1; remaining bytes ignored and `overflow` stays 0.
- With `UART_BOOT_LOADER_CHECKSUM_EN` defined: words 32'hFFFFFFFF and 32'h00000002 -> `checksum`=32'h00000001; undefined -> 0. Assert `rst` mid-WRITE -> all outputs return to reset values asynchronously.
